// File: rtl/m68k_arb_pkg.sv
// Shared types and defaults for the 68000 bus arbiter.
package m68k_arb_pkg;

    localparam int CNT_W             = 8;
    localparam int GRANT_TIMEOUT_DEF = 255;
    localparam int MIN_OWN_DEF       = 2;
    localparam int SYNC_STAGES_DEF   = 2;

    typedef enum logic [2:0] {
        ARB_OWN      = 3'd0,
        ARB_PENDING  = 3'd1,
        ARB_GRANT    = 3'd2,
        ARB_EXTERNAL = 3'd3,
        ARB_RECOVER  = 3'd4
    } arb_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/arb_sync2.sv
// Multi-flop synchronizer for asynchronous socket pins, resetting to the idle (high) level.
// Latency: STAGES clocks (never fewer than 2); no flow control.
module arb_sync2 #(
    parameter int STAGES = 2
) (
    input  logic c8m,
    input  logic s1rst,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge c8m or posedge s1rst) begin
        if (s1rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbiter: sequences BG_n against BR_n/BGACK_n and gates the local bus-cycle sequencer.
// Latency: pin to state SYNC_STAGES clocks, outputs registered one clock later; no flow control.
module m68k_bus_arbiter
    import m68k_arb_pkg::*;
#(
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
    parameter int MIN_OWN       = MIN_OWN_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic       c8m,
    input  logic       s1rst,
    input  logic       br_n,
    input  logic       bgack_n,
    input  logic       cyc_active,
    input  logic       cyc_end,
    output logic       bg_n,
    output logic       bus_owned,
    output logic       cyc_allow,
    output logic       timeout_err,
    output logic [2:0] arb_state
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(GRANT_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD   = CNT_W'(MIN_OWN);
    localparam bit               TMO_EN = (GRANT_TIMEOUT != 0);

    logic br_sync;
    logic bgack_sync;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             bg_n_q, bg_n_d;
    logic             bus_owned_q, bus_owned_d;
    logic             cyc_allow_q, cyc_allow_d;
    logic             timeout_err_q, timeout_err_d;

    arb_sync2 #(.STAGES(SYNC_STAGES)) u_sync_br (
        .c8m   (c8m),
        .s1rst (s1rst),
        .d     (br_n),
        .q     (br_sync)
    );

    arb_sync2 #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .c8m   (c8m),
        .s1rst (s1rst),
        .d     (bgack_n),
        .q     (bgack_sync)
    );

    // An asserted BGACK always wins: an external master may seize the bus from any state.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ARB_OWN: begin
                if (!bgack_sync)   state_d = ARB_EXTERNAL;
                else if (!br_sync) state_d = ARB_PENDING;
            end
            ARB_PENDING: begin
                if (!bgack_sync)                  state_d = ARB_EXTERNAL;
                else if (br_sync)                 state_d = ARB_OWN;
                else if (!cyc_active || cyc_end)  state_d = ARB_GRANT;
            end
            ARB_GRANT: begin
                if (!bgack_sync)                        state_d = ARB_EXTERNAL;
                else if (br_sync)                       state_d = ARB_RECOVER;
                else if (TMO_EN && (tmo_cnt_q == TMO))  state_d = ARB_RECOVER;
                else                                    tmo_cnt_d = sat_inc(tmo_cnt_q);
            end
            ARB_EXTERNAL: begin
                if (bgack_sync) state_d = ARB_RECOVER;
            end
            ARB_RECOVER: begin
                if (!bgack_sync)              state_d = ARB_EXTERNAL;
                else if (hold_cnt_q == '0)    state_d = ARB_OWN;
                else                          hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
            default: state_d = ARB_OWN;
        endcase

        if (state_d == ARB_GRANT && state_q != ARB_GRANT) begin
            tmo_cnt_d = '0;
        end
        if (state_d == ARB_RECOVER && state_q != ARB_RECOVER) begin
            hold_cnt_d = HOLD;
        end

        // Outputs are decoded from the next state so they change on the same edge as the state.
        bg_n_d        = (state_d != ARB_GRANT);
        bus_owned_d   = (state_d != ARB_EXTERNAL);
        cyc_allow_d   = (state_d == ARB_OWN);
        timeout_err_d = TMO_EN && (state_d == ARB_GRANT) && (tmo_cnt_d == TMO);
    end

    always_ff @(posedge c8m or posedge s1rst) begin
        if (s1rst) begin
            state_q       <= ARB_OWN;
            tmo_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            bg_n_q        <= 1'b1;
            bus_owned_q   <= 1'b1;
            cyc_allow_q   <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            bg_n_q        <= bg_n_d;
            bus_owned_q   <= bus_owned_d;
            cyc_allow_q   <= cyc_allow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bg_n        = bg_n_q;
    assign bus_owned   = bus_owned_q;
    assign cyc_allow   = cyc_allow_q;
    assign timeout_err = timeout_err_q;
    assign arb_state   = state_q;

endmodule

// File: doc/m68k_bus_arbiter.md
# m68k_bus_arbiter

Bus-arbitration controller for the 68000 bus on the PiStorm CPU socket. It samples BR_n/BGACK_n from external masters (DMA, accelerators) and sequences BG_n. It tells the bus-cycle state machine when it may start a cycle and when it must tristate its bus drivers. It sits between the socket pins and the S0–S7 bus-cycle sequencer and replaces the ad-hoc grant logic in the top level.

## Interface
- GRANT_TIMEOUT, 255: clocks in GRANT without BGACK before the grant is withdrawn; 0 disables the timeout.
- MIN_OWN, 2: clocks the PiStorm keeps the bus after regaining it before a new grant may issue.
- SYNC_STAGES, 2: synchronizer depth on br_n/bgack_n; minimum 2.
- Reset is s1rst, asynchronous, active-high.
- c8m  in  1  68000 bus clock (M68K_CLK); all state on posedge.
- s1rst  in  1  asynchronous active-high reset.
- br_n  in  1  M68K_BR_n pin, asynchronous.
- bgack_n  in  1  M68K_BGACK_n pin, asynchronous.
- cyc_active  in  1  high while the bus-cycle sequencer is in S1..S7.
- cyc_end  in  1  one-clock pulse when the sequencer completes S7.
- bg_n  out  1  M68K_BG_n pin drive.
- bus_owned  out  1  1 = PiStorm may drive AS/UDS/LDS/RW/FC/VMA/address; 0 = drivers tristated.
- cyc_allow  out  1  1 = the sequencer may leave S0 to start a new cycle.
- timeout_err  out  1  one-clock pulse on grant withdrawal by timeout.
- arb_state  out  3  current state encoding, for debug.

## Operation
- States: OWN, PENDING, GRANT, EXTERNAL, RECOVER.
- OWN: bg_n=1, bus_owned=1.
  - cyc_allow=1 unless synced BR is low.
  - Synced BR low → PENDING.
  - Synced BGACK low with no grant (unsolicited takeover) → EXTERNAL.
- PENDING: cyc_allow=0, bg_n=1.
  - A cycle in progress runs to completion.
  - Leave when cyc_active=0, or cyc_end=1 in this clock → GRANT.
  - BR negated before grant → OWN.
- GRANT: bg_n=0, cyc_allow=0.
  - bus_owned=1 until synced BGACK low, then → EXTERNAL.
  - Synced BR high with BGACK still high (request withdrawn) → RECOVER.
  - Timeout counter hits GRANT_TIMEOUT → timeout_err pulse, → RECOVER.
- EXTERNAL: bus_owned=0, bg_n=1 (BG negated once BGACK seen), cyc_allow=0.
  - Synced BGACK high → RECOVER.
- RECOVER: bus_owned=1, bg_n=1, cyc_allow=0, and the hold counter loads MIN_OWN.
  - Counter counts down to 0 → OWN.
  - BR is ignored while counting; BGACK low → EXTERNAL (an external master may seize regardless).
- Counters are 8 bits. The timeout counter clears on entry to GRANT and saturates. MIN_OWN=0 means RECOVER lasts one clock.
- Simultaneous events: BGACK low beats BR withdrawal in GRANT. cyc_end and BR low in the same clock in OWN → PENDING, then GRANT next clock.
- s1rst asserted mid-grant forces OWN immediately, with bg_n=1, bus_owned=1, cyc_allow=1, timeout_err=0, arb_state=OWN, synchronizer flops=1 and counters=0.

## Timing
- Pin-to-state latency: SYNC_STAGES clocks.
- BR falling with bus idle → bg_n low after SYNC_STAGES+2 clocks (sync, PENDING, GRANT).
- BGACK low → bus_owned=0 after SYNC_STAGES+1 clocks.
  - The top level must also gate its drivers combinationally on raw bgack_n, as it does today.
- BGACK high → bus_owned=1 after SYNC_STAGES+1 clocks; cyc_allow=1 after MIN_OWN+1 further clocks.
- All outputs are registered; no combinational pin-to-pin paths.
- bg_n never asserts while cyc_active=1 at the same posedge.

## Structure
- Package m68k_arb_pkg holds:
  - the state enum (OWN=0, PENDING=1, GRANT=2, EXTERNAL=3, RECOVER=4);
  - the GRANT_TIMEOUT/MIN_OWN defaults;
  - the 8-bit counter width constant.
- Sub-module arb_sync2: a parameterized-depth synchronizer, reset to 1, instantiated for br_n and bgack_n.

## Test plan
- Idle bus; br_n low at clock 0, bgack_n low 3 clocks after bg_n falls, high 20 clocks later → bg_n low at clock 4, bus_owned=0 during BGACK, bg_n=1 after BGACK seen, cyc_allow=1 MIN_OWN+1 clocks after bus_owned returns to 1.
- br_n low during S3 of an active cycle → bg_n stays 1 until the clock after cyc_end, and cyc_allow=0 throughout.
- br_n low then high after 5 clocks in GRANT with no BGACK → RECOVER, then OWN; no timeout_err.
- GRANT_TIMEOUT=16, br_n held low, no BGACK → timeout_err pulses at GRANT clock 16, bg_n=1 the next clock.
- bgack_n low with br_n high in OWN → EXTERNAL, bus_owned=0, bg_n stays 1 throughout.
- s1rst pulsed while in EXTERNAL → bg_n=1, bus_owned=1, arb_state=0 within the same clock; normal grant works afterwards.
